// File: rtl/dac_pkg.sv
// Shared constants, sample/state types and the two's-complement to offset-binary
// conversion used by the DAC transmit path.
package dac_pkg;

  localparam int DW = 10;
  localparam logic [DW-1:0] IDLE_CODE = 10'd512;

  typedef logic [DW-1:0] dac_sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2
  } dac_tx_state_t;

  // Flipping the sign bit is the same as adding midscale modulo 2^DW.
  function automatic dac_sample_t to_offset_bin(input dac_sample_t s);
    return s ^ {1'b1, {(DW-1){1'b0}}};
  endfunction

endpackage

// File: rtl/dac_tx_fifo.sv
// Per-channel sample FIFO; pointers carry one extra wrap bit to tell full from empty.
module dac_tx_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop  && !empty) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/dac_tx_interleave.sv
// Dual-channel DAC transmitter: CH1 while dac_clk_out=1, CH2 while 0, at clk_54/2.
// Optional ramp test pattern when built with DAC_TX_TEST_PATTERN_EN.
//
//   state | meaning
//   IDLE  | pins parked at midscale, clock low, no pops
//   SLOT1 | frame pop decision; CH1 code (or idle) goes to the pins next cycle
//   SLOT2 | held CH2 code goes to the pins next cycle
module dac_tx_interleave #(
  parameter int              DW         = dac_pkg::DW,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [DW-1:0]   IDLE_CODE  = dac_pkg::IDLE_CODE,
  parameter int              CNT_W      = 16
) (
  input  logic             clk_54,
  input  logic             rst,
  input  logic             en,
`ifdef DAC_TX_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  input  logic [DW-1:0]    ch1_data,
  input  logic             ch1_valid,
  output logic             ch1_ready,
  input  logic [DW-1:0]    ch2_data,
  input  logic             ch2_valid,
  output logic             ch2_ready,
  output logic             dac_clk_out,
  output logic [DW-1:0]    dac_data,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);

  import dac_pkg::*;

  dac_tx_state_t    state_q, state_d;
  logic [DW-1:0]    ch1_dout, ch2_dout;
  logic [DW-1:0]    data_q, hold_q;
  logic             clk_q, und_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ch1_full, ch1_empty, ch2_full, ch2_empty;
  logic             frame_ok, pop;

  assign ch1_ready = !ch1_full && !rst;
  assign ch2_ready = !ch2_full && !rst;
  assign frame_ok  = !ch1_empty && !ch2_empty;

`ifdef DAC_TX_TEST_PATTERN_EN
  logic [DW-1:0] ramp_q;

  always_ff @(posedge clk_54) begin
    if (rst || state_q == IDLE)               ramp_q <= '0;
    else if (state_q == SLOT1 && test_mode)   ramp_q <= ramp_q + DW'(1);
  end

  assign pop = (state_q == SLOT1) && frame_ok && !test_mode;
`else
  assign pop = (state_q == SLOT1) && frame_ok;
`endif

  dac_tx_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo_ch1 (
    .clk(clk_54), .rst(rst), .push(ch1_valid && ch1_ready), .din(ch1_data),
    .pop(pop), .dout(ch1_dout), .full(ch1_full), .empty(ch1_empty)
  );

  dac_tx_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo_ch2 (
    .clk(clk_54), .rst(rst), .push(ch2_valid && ch2_ready), .din(ch2_data),
    .pop(pop), .dout(ch2_dout), .full(ch2_full), .empty(ch2_empty)
  );

  // en is only sampled at frame boundaries, so a frame always completes its CH2 slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = SLOT1;
      SLOT1:   state_d = SLOT2;
      SLOT2:   state_d = en ? SLOT1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_54) begin
    if (rst) begin
      state_q <= IDLE;
      clk_q   <= 1'b0;
      data_q  <= IDLE_CODE;
      hold_q  <= IDLE_CODE;
      und_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      und_q   <= 1'b0;
      case (state_q)
        SLOT1: begin
          clk_q <= 1'b1;
`ifdef DAC_TX_TEST_PATTERN_EN
          if (test_mode) begin
            data_q <= ramp_q;
            hold_q <= ~ramp_q;
          end else
`endif
          if (frame_ok) begin
            data_q <= to_offset_bin(ch1_dout);
            hold_q <= to_offset_bin(ch2_dout);
          end else begin
            data_q <= IDLE_CODE;
            hold_q <= IDLE_CODE;
            und_q  <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SLOT2: begin
          clk_q  <= 1'b0;
          data_q <= hold_q;
        end
        default: begin
          clk_q  <= 1'b0;
          data_q <= IDLE_CODE;
        end
      endcase
    end
  end

  assign dac_clk_out  = clk_q;
  assign dac_data     = data_q;
  assign underrun     = und_q;
  assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_dac_tx_interleave.sv
// Scoreboarded bench for dac_tx_interleave: expected pin triples {clk, data, underrun}
// are queued as stimulus is planned and popped one per clk_54 cycle.
module tb_dac_tx_interleave;

  logic        clk_54 = 1'b0;
  logic        rst = 1'b1, en = 1'b0;
  logic [9:0]  ch1_data = '0, ch2_data = '0;
  logic        ch1_valid = 1'b0, ch2_valid = 1'b0;
  logic        ch1_ready, ch2_ready, dac_clk_out, underrun;
  logic [9:0]  dac_data;
  logic [15:0] underrun_cnt;
`ifdef DAC_TX_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  always #5 clk_54 = ~clk_54;

  dac_tx_interleave dut (
    .clk_54(clk_54), .rst(rst), .en(en),
`ifdef DAC_TX_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
    .ch2_data(ch2_data), .ch2_valid(ch2_valid), .ch2_ready(ch2_ready),
    .dac_clk_out(dac_clk_out), .dac_data(dac_data),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  int          n_vec = 0, n_err = 0;
  logic [11:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ob(input int s);
    return s + 512;
  endfunction

  task automatic exp_pins(input logic c, input int d, input logic u);
    exp_q.push_back({c, 10'(d), u});
  endtask

  task automatic exp_frame(input int c1, input int c2, input logic u);
    exp_pins(1'b1, c1, u);
    exp_pins(1'b0, c2, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_54);
    #1;
  endtask

  task automatic step();
    logic [11:0] e;
    tick();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pins", 32'({dac_clk_out, dac_data, underrun}), 32'(e));
    end
  endtask

  task automatic load(input int s1, input logic v1, input int s2, input logic v2);
    ch1_data = 10'(s1); ch1_valid = v1;
    ch2_data = 10'(s2); ch2_valid = v2;
    tick();
    ch1_valid = 1'b0; ch2_valid = 1'b0;
  endtask

  // en high for n frames, dropped while the last frame's CH1 slot is on the pins.
  task automatic run(input int n);
    en = 1'b1;
    step();
    repeat (2*n - 1) step();
    en = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_clk",  32'(dac_clk_out), 32'(0));
    chk("rst_data", 32'(dac_data), 32'(512));
    chk("rst_und",  32'(underrun), 32'(0));
    chk("rst_cnt",  32'(underrun_cnt), 32'(0));
    chk("rst_rdy",  32'({ch1_ready, ch2_ready}), 32'(0));
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'({ch1_ready, ch2_ready}), 32'(3));

    // empty FIFOs: every frame underruns
    exp_pins(0, 512, 0);
    repeat (3) exp_frame(512, 512, 1);
    exp_pins(0, 512, 0);
    run(3);
    chk("cnt_underrun3", 32'(underrun_cnt), 32'(3));

    // format conversion, boundary codes
    load(0, 1, 511, 1);
    load(100, 1, -100, 1);
    load(-1, 1, 1, 1);
    load(-512, 1, 0, 1);
    exp_pins(0, 512, 0);
    exp_frame(512, 1023, 0);
    exp_frame(612, 412, 0);
    exp_frame(511, 513, 0);
    exp_frame(0, 512, 0);
    exp_pins(0, 512, 0);
    run(4);
    chk("cnt_no_underrun", 32'(underrun_cnt), 32'(3));

    // fill to full, 5th sample held off until a pop frees a slot
    for (int i = 0; i < 4; i++) begin
      chk("rdy_filling", 32'({ch1_ready, ch2_ready}), 32'(3));
      ch1_data = 10'(10 * (i + 1)); ch1_valid = 1'b1;
      ch2_data = 10'(-10 * (i + 1)); ch2_valid = 1'b1;
      tick();
    end
    ch1_data = 10'(50); ch2_data = 10'(-50);
    chk("rdy_full", 32'({ch1_ready, ch2_ready}), 32'(0));
    exp_pins(0, 512, 0);
    for (int i = 1; i <= 5; i++) exp_frame(ob(10 * i), ob(-10 * i), 0);
    exp_pins(0, 512, 0);
    en = 1'b1;
    step();
    chk("rdy_before_pop", 32'({ch1_ready, ch2_ready}), 32'(0));
    step();
    chk("rdy_after_pop", 32'({ch1_ready, ch2_ready}), 32'(3));
    step();
    chk("rdy_refull", 32'({ch1_ready, ch2_ready}), 32'(0));
    ch1_valid = 1'b0; ch2_valid = 1'b0;
    repeat (7) step();
    en = 1'b0;
    repeat (2) step();

    // only CH1 has data: no pops until CH2 arrives, alignment kept
    load(7, 1, 0, 0);
    load(8, 1, 0, 0);
    load(9, 1, 0, 0);
    exp_pins(0, 512, 0);
    exp_frame(512, 512, 1);
    exp_frame(512, 512, 1);
    exp_frame(ob(7), ob(-7), 0);
    exp_pins(0, 512, 0);
    en = 1'b1;
    repeat (4) step();
    ch2_data = 10'(-7); ch2_valid = 1'b1;
    step();
    ch2_valid = 1'b0;
    step();
    en = 1'b0;
    repeat (2) step();
    chk("cnt_ch1_only", 32'(underrun_cnt), 32'(5));

    // CH1 leftovers survive idle; pair them with fresh CH2 samples
    load(0, 0, 1, 1);
    load(0, 0, 2, 1);
    exp_pins(0, 512, 0);
    exp_frame(ob(8), ob(1), 0);
    exp_frame(ob(9), ob(2), 0);
    exp_pins(0, 512, 0);
    run(2);

    // reset mid-frame flushes FIFOs, hold register and counter
    load(100, 1, -1, 1);
    load(200, 1, -2, 1);
    exp_pins(0, 512, 0);
    exp_pins(1, ob(100), 0);
    exp_pins(0, 512, 0);
    en = 1'b1;
    repeat (2) step();
    rst = 1'b1; en = 1'b0;
    step();
    chk("mid_rst_cnt", 32'(underrun_cnt), 32'(0));
    chk("mid_rst_rdy", 32'({ch1_ready, ch2_ready}), 32'(0));
    rst = 1'b0;
    #1;
    chk("mid_rst_rdy_rel", 32'({ch1_ready, ch2_ready}), 32'(3));
    exp_pins(0, 512, 0);
    exp_frame(512, 512, 1);
    exp_pins(0, 512, 0);
    run(1);
    chk("cnt_after_flush", 32'(underrun_cnt), 32'(1));

`ifdef DAC_TX_TEST_PATTERN_EN
    load(5, 1, 5, 1);
    test_mode = 1'b1;
    exp_pins(0, 512, 0);
    exp_frame(0, 1023, 0);
    exp_frame(1, 1022, 0);
    exp_frame(2, 1021, 0);
    exp_pins(0, 512, 0);
    run(3);
    test_mode = 1'b0;
    exp_pins(0, 512, 0);
    exp_frame(ob(5), ob(5), 0);
    exp_pins(0, 512, 0);
    run(1);
    chk("cnt_test_mode", 32'(underrun_cnt), 32'(1));
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
